// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard/stall controller: load-use bubbles, branch flushes,
// memory-busy freeze with a timeout watchdog, and saturating perf counters.
`timescale 1ns/1ps
module hazard_stall_unit #(
  parameter int ADDR_W   = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [ADDR_W-1:0] ex_write_addr_i,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pipe_we_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lu_hz;
  logic       freeze;
  logic       lu_bubble;

  // Every register is real, so r0 hazards are detected like any other.
  assign lu_hz = ex_valid_i & ex_memread_i &
                 ((id_uses_rs_i & (id_rs_addr_i == ex_write_addr_i)) |
                  (id_uses_rt_i & (id_rt_addr_i == ex_write_addr_i)));

  assign freeze = mem_busy_i | (state == ERROR);

  always_comb begin
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_we_o     = 1'b0;
    lu_bubble     = 1'b0;
    if (!rst_n_i || freeze) begin
      // Everything holds; a taken branch sitting in EX waits for release.
    end else if (branch_taken_i) begin
      pc_we_o       = 1'b1;
      ifid_we_o     = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      pipe_we_o     = 1'b1;
    end else if (lu_hz) begin
      idex_bubble_o = 1'b1;
      pipe_we_o     = 1'b1;
      lu_bubble     = 1'b1;
    end else begin
      pc_we_o       = 1'b1;
      ifid_we_o     = 1'b1;
      pipe_we_o     = 1'b1;
    end
  end

  // Memory-wait watchdog; ERROR is only left through reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!mem_busy_i) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == MAX_WAIT_C) begin
            state     <= ERROR;
            timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERROR: begin
          timeout_o <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (!pc_we_o && (stall_cnt_o != CNT_MAX))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (lu_bubble && (bubble_cnt_o != CNT_MAX))
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule
